bp_update_queue: RTL and testbench

BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

---
 rtl/bp_update_queue.sv | 128 ++++++++++++
 tb/tb_bp_update_queue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// Branch predictor update queue: tracks in-flight predictions and trains the PHT strictly in allocation order.
// Optional macro BPQ_RESOLVE_BYPASS_EN: a resolve of the unresolved head commits at the same edge.
module bp_update_queue #(
    parameter int GHR_BITS = 10,
    parameter int DEPTH    = 8,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [GHR_BITS-1:0] alloc_idx,
    input  logic [GHR_BITS-1:0] alloc_ghr,
    input  logic                alloc_pred,
    output logic                alloc_ready,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                resolve_valid,
    input  logic [TAG_W-1:0]    resolve_tag,
    input  logic                resolve_taken,
    input  logic                flush,
    output logic                commit_valid,
    output logic                commit_outcome,
    output logic                mispredict,
    output logic [GHR_BITS-1:0] commit_idx,
    output logic [GHR_BITS-1:0] commit_ghr,
    output logic [TAG_W:0]      count
);
    localparam logic [TAG_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]      head_q, tail_q;
    logic [DEPTH-1:0]    valid_q, resolved_q;
    logic                bubble_q;
    logic [GHR_BITS-1:0] idx_q [DEPTH];
    logic [GHR_BITS-1:0] ghr_q [DEPTH];
    logic [DEPTH-1:0]    pred_q, outcome_q;

    logic                commit_valid_q, commit_outcome_q, mispredict_q;
    logic [GHR_BITS-1:0] commit_idx_q, commit_ghr_q;

    logic [TAG_W-1:0] head_idx, tail_idx;
    logic             head_valid, head_resolved, head_outcome;
    logic             bypass_hit, pop, pop_mispredict, resolve_ok, alloc_fire;

    assign head_idx      = head_q[TAG_W-1:0];
    assign tail_idx      = tail_q[TAG_W-1:0];
    assign head_valid    = valid_q[head_idx];
    assign head_resolved = resolved_q[head_idx];
    assign count         = tail_q - head_q;

`ifdef BPQ_RESOLVE_BYPASS_EN
    assign bypass_hit = resolve_valid && (resolve_tag == head_idx) && head_valid && !head_resolved;
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_outcome   = head_resolved ? outcome_q[head_idx] : resolve_taken;
    assign pop            = !flush && head_valid && (head_resolved || bypass_hit);
    assign pop_mispredict = pop && (pred_q[head_idx] != head_outcome);
    assign resolve_ok     = !flush && resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];

    // count[TAG_W] is set only when the queue holds exactly DEPTH entries.
    assign alloc_ready = !count[TAG_W] && !flush && !pop_mispredict && !bubble_q;
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            valid_q          <= '0;
            resolved_q       <= '0;
            bubble_q         <= 1'b0;
            commit_valid_q   <= 1'b0;
            commit_outcome_q <= 1'b0;
            mispredict_q     <= 1'b0;
            commit_idx_q     <= '0;
            commit_ghr_q     <= '0;
        end else if (flush) begin
            valid_q        <= '0;
            tail_q         <= head_q;
            bubble_q       <= 1'b0;
            commit_valid_q <= 1'b0;
        end else begin
            bubble_q       <= pop_mispredict;
            commit_valid_q <= pop;
            // NOTE: later non-blocking writes to the same bit win, so the
            // invalidations below deliberately sit after the alloc/resolve updates.
            if (alloc_fire) begin
                valid_q[tail_idx]    <= 1'b1;
                resolved_q[tail_idx] <= 1'b0;
                tail_q               <= tail_q + PTR_ONE;
            end
            if (resolve_ok) begin
                resolved_q[resolve_tag] <= 1'b1;
            end
            if (pop) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= head_q + PTR_ONE;
                commit_outcome_q  <= head_outcome;
                mispredict_q      <= pop_mispredict;
                commit_idx_q      <= idx_q[head_idx];
                commit_ghr_q      <= {ghr_q[head_idx][GHR_BITS-2:0], head_outcome};
            end
            if (pop_mispredict) begin
                valid_q <= '0;
                tail_q  <= head_q + PTR_ONE;
            end
        end
    end

    // NOTE: payload storage has no reset; valid_q gates every read of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            idx_q[tail_idx]  <= alloc_idx;
            ghr_q[tail_idx]  <= alloc_ghr;
            pred_q[tail_idx] <= alloc_pred;
        end
        if (resolve_ok) begin
            outcome_q[resolve_tag] <= resolve_taken;
        end
    end

    assign commit_valid   = commit_valid_q;
    assign commit_outcome = commit_outcome_q;
    assign mispredict     = mispredict_q;
    assign commit_idx     = commit_idx_q;
    assign commit_ghr     = commit_ghr_q;
endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue (GHR_BITS=10, DEPTH=8); expected commits kept in a scoreboard queue.
// Timing expectations adapt when BPQ_RESOLVE_BYPASS_EN is defined.
module tb_bp_update_queue;
    localparam int GB = 10;
`ifdef BPQ_RESOLVE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [GB-1:0] idx;
        logic [GB-1:0] ghr;
        logic          outcome;
        logic          mis;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid = 1'b0;
    logic [GB-1:0] alloc_idx = '0;
    logic [GB-1:0] alloc_ghr = '0;
    logic          alloc_pred = 1'b0;
    logic          alloc_ready;
    logic [2:0]    alloc_tag;
    logic          resolve_valid = 1'b0;
    logic [2:0]    resolve_tag = '0;
    logic          resolve_taken = 1'b0;
    logic          flush = 1'b0;
    logic          commit_valid, commit_outcome, mispredict;
    logic [GB-1:0] commit_idx, commit_ghr;
    logic [3:0]    count;

    int   checks = 0;
    int   errors = 0;
    int   commit_cnt = 0;
    int   cycle = 0;
    int   last_commit_cycle = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    bp_update_queue #(.GHR_BITS(GB), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_ghr(alloc_ghr),
        .alloc_pred(alloc_pred), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .flush(flush),
        .commit_valid(commit_valid), .commit_outcome(commit_outcome), .mispredict(mispredict),
        .commit_idx(commit_idx), .commit_ghr(commit_ghr), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Scoreboard: every observed commit must match the oldest expected entry.
    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            commit_cnt++;
            last_commit_cycle = cycle;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: got commit idx=%h ghr=%h, required no commit", commit_idx, commit_ghr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({commit_idx, commit_ghr, commit_outcome, mispredict} !== {mon_e.idx, mon_e.ghr, mon_e.outcome, mon_e.mis}) begin
                    errors++;
                    $display("FAIL commit_fields: got idx=%h ghr=%h out=%b mis=%b, required idx=%h ghr=%h out=%b mis=%b",
                             commit_idx, commit_ghr, commit_outcome, mispredict,
                             mon_e.idx, mon_e.ghr, mon_e.outcome, mon_e.mis);
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic [GB-1:0] idx, input logic [GB-1:0] ghr,
                                    input logic outcome, input logic pred);
        exp_t e;
        e.idx     = idx;
        e.ghr     = {ghr[GB-2:0], outcome};
        e.outcome = outcome;
        e.mis     = (outcome != pred);
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        alloc_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One cycle of stimulus; alloc_ready/alloc_tag are sampled before the edge.
    task automatic drive(input logic av, input logic [GB-1:0] idx, input logic [GB-1:0] ghr, input logic pred,
                         input logic rv, input logic [2:0] rtag, input logic rtk, input logic fl,
                         output logic ok, output logic [2:0] tag);
        alloc_valid = av; alloc_idx = idx; alloc_ghr = ghr; alloc_pred = pred;
        resolve_valid = rv; resolve_tag = rtag; resolve_taken = rtk; flush = fl;
        #1;
        ok  = alloc_ready;
        tag = alloc_tag;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_commits(input int target, input int budget, input string name);
        int n = 0;
        while (commit_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (commit_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d commits, required %0d", name, commit_cnt, target);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending expected commits, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({commit_valid, mispredict, commit_outcome, commit_idx, commit_ghr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cv=%b mis=%b out=%b idx=%h ghr=%h, required all 0",
                     commit_valid, mispredict, commit_outcome, commit_idx, commit_ghr);
        end
        checks++;
        if (count !== 4'd0 || alloc_tag !== 3'd0 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got count=%0d tag=%0d ready=%b, required 0 0 1", count, alloc_tag, alloc_ready);
        end
    endtask

    task automatic test_basic();
        logic ok; logic [2:0] tag; int c_e; int base;
        apply_reset();
        base = commit_cnt;
        drive(1, 10'h155, 10'h0AA, 1, 0, 0, 0, 0, ok, tag);
        checks++;
        if (ok !== 1'b1 || tag !== 3'd0) begin
            errors++;
            $display("FAIL basic_alloc: got ready=%b tag=%0d, required 1 0", ok, tag);
        end
        exp_q.push_back(mk_exp(10'h155, 10'h0AA, 1'b1, 1'b1));
        drive(0, 0, 0, 0, 1, 3'd0, 1, 0, ok, tag);
        c_e = cycle;
        wait_commits(base + 1, 10, "basic");
        checks++;
        if (last_commit_cycle - c_e != LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required %0d", last_commit_cycle - c_e, LAT);
        end
        idle(2);
        checks++;
        if (count !== 4'd0 || commit_valid !== 1'b0 || commit_cnt != base + 1) begin
            errors++;
            $display("FAIL basic_after: got count=%0d cv=%b commits=%0d, required 0 0 %0d", count, commit_valid, commit_cnt - base, 1);
        end
        check_drained("basic");
    endtask

    task automatic test_full();
        logic ok; logic [2:0] tag; int c_e; int base;
        apply_reset();
        base = commit_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1, 10'(i * 3 + 1), 10'(i + 100), i[0], 0, 0, 0, 0, ok, tag);
            checks++;
            if (ok !== 1'b1 || tag !== 3'(i)) begin
                errors++;
                $display("FAIL full_alloc%0d: got ready=%b tag=%0d, required 1 %0d", i, ok, tag, i);
            end
            exp_q.push_back(mk_exp(10'(i * 3 + 1), 10'(i + 100), i[0], i[0]));
        end
        checks++;
        if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_state: got ready=%b count=%0d, required 0 8", alloc_ready, count);
        end
        drive(1, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 0, ok, tag);
        checks++;
        if (ok !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_refuse: got ready=%b count=%0d, required 0 8", ok, count);
        end
        for (int t = 7; t >= 1; t--) drive(0, 0, 0, 0, 1, 3'(t), t[0], 0, ok, tag);
        idle(2);
        checks++;
        if (commit_cnt != base) begin
            errors++;
            $display("FAIL full_early_commit: got %0d commits, required 0", commit_cnt - base);
        end
        drive(0, 0, 0, 0, 1, 3'd0, 1'b0, 0, ok, tag);
        c_e = cycle;
        wait_commits(base + 8, 20, "full");
        checks++;
        if (last_commit_cycle - c_e != LAT + 7) begin
            errors++;
            $display("FAIL full_spacing: got last commit at +%0d, required +%0d", last_commit_cycle - c_e, LAT + 7);
        end
        check_drained("full");
    endtask

    task automatic test_mispredict();
        logic ok; logic [2:0] tag; int base;
        apply_reset();
        base = commit_cnt;
        for (int i = 0; i < 4; i++) drive(1, 10'(16 + i), 10'(32 + i), 1, 0, 0, 0, 0, ok, tag);
        exp_q.push_back(mk_exp(10'h010, 10'h020, 1'b1, 1'b1));
        exp_q.push_back(mk_exp(10'h011, 10'h021, 1'b0, 1'b1));
        drive(0, 0, 0, 0, 1, 3'd1, 0, 0, ok, tag);
        drive(0, 0, 0, 0, 1, 3'd2, 1, 0, ok, tag);
        drive(0, 0, 0, 0, 1, 3'd3, 1, 0, ok, tag);
        drive(0, 0, 0, 0, 1, 3'd0, 1, 0, ok, tag);
        idle(LAT);
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL mis_pop_ready: got %b, required 0", alloc_ready);
        end
        idle(1);
        checks++;
        if (alloc_ready !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL mis_bubble: got ready=%b count=%0d, required 0 0", alloc_ready, count);
        end
        idle(1);
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 3'd2 || commit_cnt != base + 2) begin
            errors++;
            $display("FAIL mis_recover: got ready=%b tag=%0d commits=%0d, required 1 2 2", alloc_ready, alloc_tag, commit_cnt - base);
        end
        idle(4);
        check_drained("mis");
    endtask

    // Continues from test_mispredict: head = tail = 2.
    task automatic test_flush();
        logic ok; logic [2:0] tag; int base;
        base = commit_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1, 10'(200 + i), 10'(300 + i), 1, 0, 0, 0, 0, ok, tag);
            checks++;
            if (tag !== 3'(2 + i)) begin
                errors++;
                $display("FAIL flush_alloc%0d: got tag=%0d, required %0d", i, tag, 2 + i);
            end
        end
        drive(0, 0, 0, 0, 1, 3'd3, 1, 0, ok, tag);
        drive(1, 10'h111, 10'h222, 1, 1, 3'd2, 1, 1, ok, tag);
        checks++;
        if (ok !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b, required 0", ok);
        end
        checks++;
        if (count !== 4'd0 || alloc_tag !== 3'd2 || commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got count=%0d tag=%0d cv=%b, required 0 2 0", count, alloc_tag, commit_valid);
        end
        drive(1, 10'h0C0, 10'h0C1, 0, 0, 0, 0, 0, ok, tag);
        if (LAT == 0) exp_q.push_back(mk_exp(10'h0C0, 10'h0C1, 1'b0, 1'b0));
        drive(0, 0, 0, 0, 1, 3'd2, 0, 0, ok, tag);
        drive(0, 0, 0, 0, 0, 0, 0, 1, ok, tag);
        idle(3);
        checks++;
        if (commit_cnt != base + 1 - LAT || count !== 4'd0 || alloc_tag !== 3'd3 - 3'(LAT)) begin
            errors++;
            $display("FAIL flush_pending: got commits=%0d count=%0d tag=%0d, required %0d 0 %0d",
                     commit_cnt - base, count, alloc_tag, 1 - LAT, 3 - LAT);
        end
        check_drained("flush");
    endtask

    task automatic test_wrap();
        logic ok; logic [2:0] tag; int base; logic [19:0] pv; logic [GB-1:0] ri, rg;
        apply_reset();
        base = commit_cnt;
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) pv[k] = 1'($urandom_range(0, 1));
            ri = 10'($urandom_range(0, 1023));
            rg = 10'($urandom_range(0, 1023));
            drive(k < 20, ri, rg, (k < 20) ? pv[k] : 1'b0,
                  k > 0, 3'((k + 7) % 8), (k > 0) ? pv[(k + 19) % 20] : 1'b0, 0, ok, tag);
            if (k < 20) begin
                exp_q.push_back(mk_exp(ri, rg, pv[k], pv[k]));
                checks++;
                if (ok !== 1'b1 || tag !== 3'(k % 8)) begin
                    errors++;
                    $display("FAIL wrap_alloc%0d: got ready=%b tag=%0d, required 1 %0d", k, ok, tag, k % 8);
                end
            end
        end
        wait_commits(base + 20, 20, "wrap");
        idle(3);
        checks++;
        if (commit_cnt != base + 20 || count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_total: got commits=%0d count=%0d, required 20 0", commit_cnt - base, count);
        end
        check_drained("wrap");
    endtask

    task automatic test_duplicate();
        logic ok; logic [2:0] tag; int c_e; int base;
        apply_reset();
        base = commit_cnt;
        drive(1, 10'h3C3, 10'h0F0, 1, 0, 0, 0, 0, ok, tag);
        exp_q.push_back(mk_exp(10'h3C3, 10'h0F0, 1'b1, 1'b1));
        drive(0, 0, 0, 0, 1, 3'd0, 1, 0, ok, tag);
        c_e = cycle;
        drive(0, 0, 0, 0, 1, 3'd0, 0, 0, ok, tag);
        wait_commits(base + 1, 10, "dup");
        checks++;
        if (last_commit_cycle - c_e != LAT) begin
            errors++;
            $display("FAIL dup_latency: got %0d, required %0d", last_commit_cycle - c_e, LAT);
        end
        drive(0, 0, 0, 0, 1, 3'd0, 0, 0, ok, tag);
        idle(3);
        checks++;
        if (commit_cnt != base + 1 || count !== 4'd0) begin
            errors++;
            $display("FAIL dup_single: got commits=%0d count=%0d, required 1 0", commit_cnt - base, count);
        end
        check_drained("dup");
    endtask

    task automatic test_reset_mid();
        logic ok; logic [2:0] tag; int base;
        apply_reset();
        base = commit_cnt;
        drive(1, 10'h055, 10'h066, 1, 0, 0, 0, 0, ok, tag);
        drive(1, 10'h077, 10'h088, 0, 0, 0, 0, 0, ok, tag);
        drive(0, 0, 0, 0, 1, 3'd1, 0, 0, ok, tag);
        drive(0, 0, 0, 0, 1, 3'd0, 1, 0, ok, tag);
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || commit_valid !== 1'b0 || commit_idx !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got count=%0d cv=%b idx=%h, required 0 0 0", count, commit_valid, commit_idx);
        end
        idle(2);
        rst = 1'b0;
        idle(3);
        checks++;
        if (commit_cnt != base || alloc_tag !== 3'd0 || count !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_after: got commits=%0d tag=%0d count=%0d, required 0 0 0", commit_cnt - base, alloc_tag, count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_flush();
        test_wrap();
        test_duplicate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
